ps2_keyboard_rx: RTL and testbench
==================================

Name: ps2_keyboard_rx

Overview:
- PS/2 keyboard receiver on the CPU clock domain; consumes the raw keyboard_clock/keyboard_data pins and feeds scan-code bytes to the CPU I/O bus.
- Synchronises and glitch-filters both lines, deframes 11-bit PS/2 frames (start, 8 data LSB-first, odd parity, stop) and checks them.
- Buffers valid bytes in a small FIFO so the CPU can poll without losing make/break sequences (e.g. F0 xx, E0 F0 xx).

Parameters:
- FILTER, 4, consecutive equal synchronised samples required before the filtered PS/2 clock/data level changes.
- TIMEOUT, 150, CLK_CPU cycles without a filtered PS/2 clock falling edge before a partial frame is abandoned.
- DEPTH, 8, FIFO entries; power of two, minimum 2.

Ports:
- CLK_CPU  input  1  system clock; all logic on its rising edge.
- resetp  input  1  synchronous, active-high reset.
- keyboard_clock  input  1  raw PS/2 clock pin, asynchronous.
- keyboard_data  input  1  raw PS/2 data pin, asynchronous.
- rd_en  input  1  pop the FIFO head this cycle.
- clear_err  input  1  clear the sticky error flags.
- rd_data  output  8  FIFO head byte (show-ahead), valid while rd_valid is 1.
- rd_valid  output  1  FIFO not empty.
- fifo_count  output  $clog2(DEPTH)+1  number of stored bytes.
- overflow  output  1  sticky: a good byte was dropped because the FIFO was full.
- frame_err  output  1  sticky: bad start, parity or stop bit, or a timeout mid-frame.

Behaviour:
- Reset (resetp=1 at a clock edge):
  - FSM to IDLE; FIFO emptied; rd_valid=0, fifo_count=0, rd_data=0, overflow=0, frame_err=0.
  - Synchroniser and filter registers set to 1 (the PS/2 idle level).
  - Reset mid-frame discards the partial frame.
- Input conditioning:
  - Each pin passes through a 2-FF synchroniser.
  - The filtered level changes only after FILTER consecutive identical synchronised samples.
  - fall = filtered clock was 1 in the previous cycle and is 0 now.
  - Data is sampled from the filtered data line in the same cycle fall is asserted.
- FSM, advancing only on fall:
  - IDLE: data=0 -> DATA with bit counter cleared. data=1 -> stay in IDLE and set frame_err (bad start bit).
  - DATA: shift the sampled bit into shift[7] (LSB-first assembly). After the 8th bit -> PARITY.
  - PARITY: store the bit -> STOP.
  - STOP: the frame is good if stop=1 and the XOR of the 8 data bits and the parity bit = 1 (odd parity). Good frame -> push; bad frame -> set frame_err, no push. Either way -> IDLE.
- Timeout:
  - A counter clears on every fall and increments otherwise; it saturates and is ignored in IDLE.
  - In any state other than IDLE, reaching TIMEOUT -> IDLE, set frame_err, discard the partial frame.
- Push timing: the push is registered at the clock edge ending the cycle in which the stop-bit fall is seen. rd_valid and the byte are visible on the next cycle.
- FIFO:
  - Circular buffer; read and write pointers wrap modulo DEPTH; fifo_count = writes − reads.
  - rd_en with rd_valid=0 is ignored with no pointer change.
  - Push while full and no pop in the same cycle: byte dropped, overflow=1, contents unchanged.
  - Push and pop in the same cycle: both take effect and fifo_count is unchanged, including when full (no overflow in that case).
  - Push into an empty FIFO with rd_en=1 in the same cycle: the pop is ignored because rd_valid was 0.
- Sticky flags:
  - clear_err=1 clears overflow and frame_err at the next edge.
  - If a new error occurs in the same cycle as clear_err, the flag stays set (set wins).
- No transmit path; the block never drives the PS/2 pins.

Test Plan:
- Good frame for 0x1C (bits 0,0,0,1,1,1,0,0,0,0,1), PS/2 clock period 40 CPU cycles -> rd_valid=1 one cycle after the stop-bit fall; rd_data=0x1C; fifo_count=1; no error flags.
- Sequence 0xF0 (parity 1) then 0x1C, then rd_en pulsed twice -> rd_data reads 0xF0 then 0x1C; fifo_count goes 2, 1, 0; rd_valid=0 after the second pop.
- 0x1C sent with parity bit 1 -> no push; frame_err=1. A following good 0x29 is received normally. clear_err -> frame_err=0.
- Frame stopped after 5 data bits, 200-cycle gap, then a full good 0x5A -> frame_err=1; only 0x5A appears in the FIFO.
- 9 good bytes 0x01..0x09 sent with no reads (DEPTH=8) -> fifo_count=8; overflow=1; reads return 0x01..0x08. Repeat with rd_en coincident with the 9th push -> no overflow; fifo_count stays 8.
- Single-cycle glitches on keyboard_clock (width < FILTER) during a frame; resetp pulsed mid-frame -> glitches cause no extra bit shifts; reset empties the FIFO, clears flags, and the next frame is received correctly.

Source files
------------

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: conditions the raw PS/2 clock/data pins, deframes
// 11-bit frames (start, 8 data LSB-first, odd parity, stop) and queues good
// scan-code bytes in a small show-ahead FIFO for the CPU to poll.
module ps2_keyboard_rx #(
  parameter int FILTER  = 4,    // equal synchronised samples needed to change a filtered level
  parameter int TIMEOUT = 150,  // cycles without a clock fall before a partial frame is dropped
  parameter int DEPTH   = 8     // FIFO entries, power of two, >= 2
) (
  input  logic                     CLK_CPU,
  input  logic                     resetp,
  input  logic                     keyboard_clock,
  input  logic                     keyboard_data,
  input  logic                     rd_en,
  input  logic                     clear_err,
  output logic [7:0]               rd_data,
  output logic                     rd_valid,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow,
  output logic                     frame_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = $clog2(FILTER + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [FW-1:0] FILT_LAST   = FW'(FILTER - 1);
  localparam logic [TW-1:0] TIMEOUT_VAL = TW'(TIMEOUT);
  localparam logic [AW:0]   FULL_COUNT  = (AW + 1)'(DEPTH);

  // ---------------------------------------------------------------------
  // Input conditioning: bit 0 is the PS/2 clock, bit 1 is the PS/2 data.
  // ---------------------------------------------------------------------
  logic [1:0] pin_raw;
  logic [1:0] pin_filt;

  assign pin_raw = {keyboard_data, keyboard_clock};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cond
      logic          sync1_reg;
      logic          sync2_reg;
      logic          level_reg;
      logic [FW-1:0] run_reg;

      // Two-FF synchroniser followed by a run-length filter: the filtered
      // level only follows the pin after FILTER consecutive differing samples.
      always_ff @(posedge CLK_CPU) begin
        if (resetp) begin
          sync1_reg <= 1'b1;
          sync2_reg <= 1'b1;
          level_reg <= 1'b1;
          run_reg   <= '0;
        end else begin
          sync1_reg <= pin_raw[gi];
          sync2_reg <= sync1_reg;
          if (sync2_reg != level_reg) begin
            if (run_reg == FILT_LAST) begin
              level_reg <= sync2_reg;
              run_reg   <= '0;
            end else begin
              run_reg <= run_reg + FW'(1);
            end
          end else begin
            run_reg <= '0;
          end
        end
      end

      assign pin_filt[gi] = level_reg;
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Frame deserialiser
  // ---------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  state_t        state_reg;
  logic [2:0]    bit_cnt_reg;
  logic [7:0]    shift_reg;
  logic          parity_reg;
  logic [TW-1:0] idle_cnt_reg;
  logic          clk_prev_reg;
  logic          frame_err_reg;

  logic fall;
  logic data_bit;
  logic frame_good;
  logic push;

  assign fall     = clk_prev_reg & ~pin_filt[0];
  assign data_bit = pin_filt[1];

  // Evaluated in STOP: stop bit high and odd parity over data plus parity bit.
  assign frame_good = data_bit & (^{shift_reg, parity_reg});

  // The byte is written into the FIFO on the edge that ends the stop-bit fall cycle.
  assign push = (state_reg == ST_STOP) & fall & frame_good;

  // Frame FSM advancing on filtered clock falls, with timeout and sticky frame error.
  always_ff @(posedge CLK_CPU) begin
    if (resetp) begin
      state_reg     <= ST_IDLE;
      bit_cnt_reg   <= '0;
      shift_reg     <= '0;
      parity_reg    <= 1'b0;
      idle_cnt_reg  <= '0;
      clk_prev_reg  <= 1'b1;
      frame_err_reg <= 1'b0;
    end else begin
      clk_prev_reg <= pin_filt[0];

      // Clear first so that an error raised in the same cycle wins.
      if (clear_err) begin
        frame_err_reg <= 1'b0;
      end

      if (fall) begin
        idle_cnt_reg <= '0;
      end else if (idle_cnt_reg != TIMEOUT_VAL) begin
        idle_cnt_reg <= idle_cnt_reg + TW'(1);
      end

      if (fall) begin
        case (state_reg)
          ST_IDLE: begin
            if (!data_bit) begin
              state_reg   <= ST_DATA;
              bit_cnt_reg <= '0;
            end else begin
              frame_err_reg <= 1'b1;
            end
          end
          ST_DATA: begin
            shift_reg   <= {data_bit, shift_reg[7:1]};
            bit_cnt_reg <= bit_cnt_reg + 3'd1;
            if (bit_cnt_reg == 3'd7) begin
              state_reg <= ST_PARITY;
            end
          end
          ST_PARITY: begin
            parity_reg <= data_bit;
            state_reg  <= ST_STOP;
          end
          ST_STOP: begin
            if (!frame_good) begin
              frame_err_reg <= 1'b1;
            end
            state_reg <= ST_IDLE;
          end
          default: begin
            state_reg <= ST_IDLE;
          end
        endcase
      end else if ((state_reg != ST_IDLE) && (idle_cnt_reg == TIMEOUT_VAL)) begin
        // Keyboard stalled mid-frame: abandon whatever was collected.
        state_reg     <= ST_IDLE;
        frame_err_reg <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Show-ahead FIFO
  // ---------------------------------------------------------------------
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic [7:0]    rd_data_reg;
  logic          overflow_reg;

  logic          pop;
  logic          full;
  logic          push_eff;
  logic          drop;
  logic [AW-1:0] head_ptr_next;
  logic [AW:0]   count_next;
  logic [7:0]    rd_data_next;

  assign pop      = rd_en & (count_reg != '0);
  assign full     = (count_reg == FULL_COUNT);
  assign push_eff = push & (~full | pop);
  assign drop     = push & full & ~pop;

  // Next head pointer, occupancy and head byte; a push landing on the new
  // head slot is forwarded since the array is written on the same edge.
  always_comb begin
    head_ptr_next = pop ? (rd_ptr_reg + AW'(1)) : rd_ptr_reg;

    count_next = count_reg;
    if (push_eff && !pop) begin
      count_next = count_reg + (AW + 1)'(1);
    end else if (!push_eff && pop) begin
      count_next = count_reg - (AW + 1)'(1);
    end

    rd_data_next = rd_data_reg;
    if (count_next != '0) begin
      if (push_eff && (head_ptr_next == wr_ptr_reg)) begin
        rd_data_next = shift_reg;
      end else begin
        rd_data_next = mem[head_ptr_next];
      end
    end
  end

  // Storage array, written only when a good byte is accepted.
  always_ff @(posedge CLK_CPU) begin
    if (push_eff) begin
      mem[wr_ptr_reg] <= shift_reg;
    end
  end

  // Pointers, occupancy, registered head byte and the sticky overflow flag.
  always_ff @(posedge CLK_CPU) begin
    if (resetp) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      rd_data_reg  <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push_eff) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      rd_ptr_reg  <= head_ptr_next;
      count_reg   <= count_next;
      rd_data_reg <= rd_data_next;
      if (clear_err) begin
        overflow_reg <= 1'b0;
      end
      if (drop) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  assign rd_data    = rd_data_reg;
  assign rd_valid   = (count_reg != '0);
  assign fifo_count = count_reg;
  assign overflow   = overflow_reg;
  assign frame_err  = frame_err_reg;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Self-checking bench for ps2_keyboard_rx: a PS/2 device model drives frames,
// expected bytes go into a scoreboard queue, and a reader/monitor process pops
// and compares whenever the DUT hands out a byte.
module tb_ps2_keyboard_rx;

  localparam int FILTER  = 4;
  localparam int TIMEOUT = 150;
  localparam int DEPTH   = 8;
  localparam int HALF    = 20;               // PS/2 clock half period in CPU cycles
  localparam int CW      = $clog2(DEPTH) + 1;

  logic          CLK_CPU;
  logic          resetp;
  logic          keyboard_clock;
  logic          keyboard_data;
  logic          rd_en;
  logic          clear_err;
  logic [7:0]    rd_data;
  logic          rd_valid;
  logic [CW-1:0] fifo_count;
  logic          overflow;
  logic          frame_err;

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_q[$];
  bit exp_ferr  = 1'b0;
  bit exp_ovf   = 1'b0;
  bit read_auto = 1'b0;
  bit rd_force  = 1'b0;

  ps2_keyboard_rx #(
    .FILTER (FILTER),
    .TIMEOUT(TIMEOUT),
    .DEPTH  (DEPTH)
  ) dut (
    .CLK_CPU       (CLK_CPU),
    .resetp        (resetp),
    .keyboard_clock(keyboard_clock),
    .keyboard_data (keyboard_data),
    .rd_en         (rd_en),
    .clear_err     (clear_err),
    .rd_data       (rd_data),
    .rd_valid      (rd_valid),
    .fifo_count    (fifo_count),
    .overflow      (overflow),
    .frame_err     (frame_err)
  );

  initial begin
    CLK_CPU = 1'b0;
    forever #5 CLK_CPU = ~CLK_CPU;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: actual=time limit reached required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge CLK_CPU);
  endtask

  // Reader and monitor: drives rd_en and checks every byte the DUT hands out.
  initial begin
    rd_en = 1'b0;
    forever begin
      @(negedge CLK_CPU);
      if (resetp) rd_en = 1'b0;
      else if (read_auto) rd_en = ($urandom_range(0, 3) == 0);
      else rd_en = rd_force;
      if (rd_en && (rd_valid || exp_q.size() != 0)) begin
        check("rd_valid_at_pop", int'(rd_valid), int'(exp_q.size() != 0));
        if (rd_valid && exp_q.size() != 0) begin
          check("rd_data_pop", int'(rd_data), int'(exp_q[0]));
          $display("pop   byte=0x%02h expected=0x%02h", rd_data, exp_q[0]);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic check_flags(input string tag);
    check({tag, "_frame_err"}, int'(frame_err), int'(exp_ferr));
    check({tag, "_overflow"}, int'(overflow), int'(exp_ovf));
  endtask

  task automatic check_state(input string tag);
    check_flags(tag);
    check({tag, "_count"}, int'(fifo_count), exp_q.size());
    check({tag, "_rd_valid"}, int'(rd_valid), int'(exp_q.size() != 0));
    if (exp_q.size() != 0) check({tag, "_rd_data"}, int'(rd_data), int'(exp_q[0]));
  endtask

  task automatic clear_flags();
    @(negedge CLK_CPU);
    clear_err = 1'b1;
    @(negedge CLK_CPU);
    clear_err = 1'b0;
    exp_ferr  = 1'b0;
    exp_ovf   = 1'b0;
  endtask

  task automatic pulse_read();
    @(posedge CLK_CPU); #1;
    rd_force = 1'b1;
    @(posedge CLK_CPU); #1;
    rd_force = 1'b0;
    wait_neg(1);
  endtask

  task automatic drain(input string tag);
    read_auto = 1'b1;
    for (int t = 0; t < 3000 && exp_q.size() != 0; t++) @(posedge CLK_CPU);
    read_auto = 1'b0;
    wait_neg(3);
    check({tag, "_drained"}, int'(exp_q.size() == 0), 1);
    check({tag, "_count_after_drain"}, int'(fifo_count), exp_q.size());
  endtask

  // PS/2 device model: data changes mid-high phase, receiver samples on the fall.
  // Expected result of a complete frame: pushed if start=0, odd parity and
  // stop=1, unless DEPTH bytes are already waiting (then overflow).
  task automatic send_frame(input logic [7:0] d, input bit par_bad, input bit stop_bad,
                            input bit start_bad, input int nbits, input bit glitch,
                            input bit check_lat, input bit pop_at_push);
    logic [10:0] b;
    bit good;
    int gw;
    b[0]   = start_bad;
    b[8:1] = d;
    b[9]   = (~^d) ^ par_bad;
    b[10]  = ~stop_bad;
    good   = !par_bad && !stop_bad && !start_bad;
    gw     = $urandom_range(1, FILTER - 1);
    @(negedge CLK_CPU);
    for (int i = 0; i < nbits; i++) begin
      keyboard_data = b[i];
      if (glitch && i == 2) begin
        wait_neg(4);
        keyboard_clock = 1'b0;
        wait_neg(gw);
        keyboard_clock = 1'b1;
        wait_neg(HALF / 2 - 4 - gw);
      end else begin
        wait_neg(HALF / 2);
      end
      keyboard_clock = 1'b0;
      if (i == 10) begin
        repeat (FILTER + 2) @(posedge CLK_CPU);
        #1;
        if (check_lat) check("rd_valid_before_push", int'(rd_valid), int'(exp_q.size() != 0));
        if (pop_at_push) rd_force = 1'b1;
        @(posedge CLK_CPU); #1;
        rd_force = 1'b0;
        if (good) begin
          if (exp_q.size() < DEPTH) exp_q.push_back(d);
          else exp_ovf = 1'b1;
        end else begin
          exp_ferr = 1'b1;
        end
        $display("frame byte=0x%02h good=%0d fifo_count=%0d", d, good, fifo_count);
        check("count_after_push", int'(fifo_count), exp_q.size());
        if (check_lat) check("rd_valid_after_push", int'(rd_valid), int'(exp_q.size() != 0));
        wait_neg(HALF - FILTER - 3);
      end else if (glitch && i == 5) begin
        wait_neg(8);
        keyboard_clock = 1'b1;
        wait_neg(gw);
        keyboard_clock = 1'b0;
        wait_neg(HALF - 8 - gw);
      end else begin
        wait_neg(HALF);
      end
      keyboard_clock = 1'b1;
      wait_neg(HALF / 2);
    end
    keyboard_data = 1'b1;
    if (nbits < 11) $display("partial frame bits=%0d", nbits);
  endtask

  initial begin
    logic [7:0] d;
    int r;
    resetp         = 1'b1;
    keyboard_clock = 1'b1;
    keyboard_data  = 1'b1;
    clear_err      = 1'b0;
    repeat (3) @(posedge CLK_CPU);
    @(negedge CLK_CPU);
    check("reset_rd_valid", int'(rd_valid), 0);
    check("reset_count", int'(fifo_count), 0);
    check("reset_rd_data", int'(rd_data), 0);
    check("reset_overflow", int'(overflow), 0);
    check("reset_frame_err", int'(frame_err), 0);
    resetp = 1'b0;
    wait_neg(5);

    // Single good frame with exact push latency.
    send_frame(8'h1C, 0, 0, 0, 11, 0, 1, 0);
    wait_neg(2);
    check_state("t1");
    check("t1_byte", int'(rd_data), 8'h1C);
    pulse_read();
    check_state("t1_read");

    // Two-byte sequence popped one at a time.
    send_frame(8'hF0, 0, 0, 0, 11, 0, 0, 0);
    send_frame(8'h1C, 0, 0, 0, 11, 0, 0, 0);
    check_state("t2_two");
    pulse_read();
    check_state("t2_pop1");
    pulse_read();
    check_state("t2_pop2");

    // Parity error, recovery, clear; then a bad start bit.
    send_frame(8'h1C, 1, 0, 0, 11, 0, 0, 0);
    check_state("t3_parity");
    send_frame(8'h29, 0, 0, 0, 11, 0, 0, 0);
    check_state("t3_good");
    clear_flags();
    check_state("t3_clear");
    pulse_read();
    send_frame(8'hFF, 0, 0, 1, 11, 0, 0, 0);
    check_state("t3_start");
    send_frame(8'h44, 0, 1, 0, 11, 0, 0, 0);
    check_state("t3_stop");
    clear_flags();

    // Timeout mid-frame, then a good frame.
    send_frame(8'hB3, 0, 0, 0, 6, 0, 0, 0);
    wait_neg(200);
    exp_ferr = 1'b1;
    check_state("t4_timeout");
    send_frame(8'h5A, 0, 0, 0, 11, 0, 0, 0);
    check_state("t4_after");
    drain("t4");
    clear_flags();

    // Overflow with no reads, then pop coincident with the ninth push.
    for (int k = 1; k <= 9; k++) send_frame(8'(k), 0, 0, 0, 11, 0, 0, 0);
    check_state("t5_ovf");
    drain("t5a");
    clear_flags();
    check_state("t5_clear");
    for (int k = 1; k <= 9; k++) send_frame(8'(k), 0, 0, 0, 11, 0, 0, (k == 9));
    check_state("t5_coincident");
    drain("t5b");

    // Clock glitches shorter than the filter, then reset mid-frame.
    send_frame(8'h3A, 0, 0, 0, 11, 1, 0, 0);
    send_frame(8'hC5, 0, 0, 0, 11, 1, 0, 0);
    check_state("t6_glitch");
    drain("t6a");
    send_frame(8'h11, 0, 0, 0, 11, 0, 0, 0);
    send_frame(8'h22, 1, 0, 0, 11, 0, 0, 0);
    send_frame(8'h6E, 0, 0, 0, 5, 0, 0, 0);
    @(negedge CLK_CPU);
    resetp = 1'b1;
    @(negedge CLK_CPU);
    resetp = 1'b0;
    exp_q.delete();
    exp_ferr = 1'b0;
    exp_ovf  = 1'b0;
    check_state("t6_reset");
    check("t6_reset_rd_data", int'(rd_data), 0);
    send_frame(8'h76, 0, 0, 0, 11, 0, 0, 0);
    check_state("t6_after_reset");
    drain("t6b");

    // Randomised frames with random reads.
    read_auto = 1'b1;
    for (int n = 0; n < 36; n++) begin
      r = $urandom_range(0, 15);
      d = 8'($urandom);
      if (r == 3) d = 8'hFF;
      send_frame(d, (r <= 1), (r == 2), (r == 3), 11, ($urandom_range(0, 3) == 0), 0, 0);
      wait_neg($urandom_range(0, 30));
      check_flags("rand");
      if ($urandom_range(0, 3) == 0) clear_flags();
    end
    drain("rand");
    check_state("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
